// File: rtl/set_alarm_ctrl.sv
// Alarm-time entry controller: walks hour, minute and on/off fields with mode/inc buttons.
// Optional macro SET_ALARM_EDGE_DETECT_EN turns button levels into single rising-edge presses.
module set_alarm_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_alarm_en,
    input  logic       mode_button,
    input  logic       inc_button,
    output logic [4:0] o_hours,
    output logic [5:0] o_minutes,
    output logic       ack_flag,
    output logic       on_off_alarm
);

    typedef enum logic [2:0] {
        IDLE,
        HOURS,
        MINUTES,
        ONOFF,
        DONE
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] hours_q, hours_d;
    logic [5:0] minutes_q, minutes_d;
    logic       on_off_q, on_off_d;
    logic       ack_q, ack_d;
    logic       mode_press;
    logic       inc_press;

`ifdef SET_ALARM_EDGE_DETECT_EN
    logic mode_btn_q;
    logic inc_btn_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_btn_q <= 1'b0;
            inc_btn_q  <= 1'b0;
        end else begin
            mode_btn_q <= mode_button;
            inc_btn_q  <= inc_button;
        end
    end

    assign mode_press = mode_button & ~mode_btn_q;
    assign inc_press  = inc_button & ~inc_btn_q;
`else
    assign mode_press = mode_button;
    assign inc_press  = inc_button;
`endif

    // IDLE shares the HOURS decode so a press in the enabling cycle is not lost.
    always_comb begin
        state_d   = state_q;
        hours_d   = hours_q;
        minutes_d = minutes_q;
        on_off_d  = on_off_q;
        ack_d     = 1'b0;
        case (state_q)
            IDLE, HOURS: begin
                if (!set_alarm_en) begin
                    state_d = IDLE;
                end else if (mode_press) begin
                    state_d = MINUTES;
                end else begin
                    state_d = HOURS;
                    if (inc_press) begin
                        hours_d = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
                    end
                end
            end
            MINUTES: begin
                if (!set_alarm_en) begin
                    state_d = IDLE;
                end else if (mode_press) begin
                    state_d = ONOFF;
                end else if (inc_press) begin
                    minutes_d = (minutes_q == 6'd59) ? 6'd0 : minutes_q + 6'd1;
                end
            end
            ONOFF: begin
                if (!set_alarm_en) begin
                    state_d = IDLE;
                end else if (mode_press) begin
                    state_d = DONE;
                    ack_d   = 1'b1;
                end else if (inc_press) begin
                    on_off_d = ~on_off_q;
                end
            end
            DONE: begin
                if (!set_alarm_en) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hours_q   <= 5'd0;
            minutes_q <= 6'd0;
            on_off_q  <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hours_q   <= hours_d;
            minutes_q <= minutes_d;
            on_off_q  <= on_off_d;
            ack_q     <= ack_d;
        end
    end

    assign o_hours      = hours_q;
    assign o_minutes    = minutes_q;
    assign on_off_alarm = on_off_q;
    assign ack_flag     = ack_q;

endmodule

// File: tb/tb_set_alarm_ctrl.sv
// Self-checking bench for set_alarm_ctrl: vector table plus hand-written wrap, abort and hold sequences.
module tb_set_alarm_ctrl;

    logic       clk;
    logic       rst;
    logic       set_alarm_en;
    logic       mode_button;
    logic       inc_button;
    logic [4:0] o_hours;
    logic [5:0] o_minutes;
    logic       ack_flag;
    logic       on_off_alarm;

    typedef struct {
        logic       rst;
        logic       en;
        logic       mode;
        logic       inc;
        logic [4:0] hours;
        logic [5:0] minutes;
        logic       on_off;
        logic       ack;
    } vec_t;

    typedef struct {
        logic [4:0] hours;
        logic [5:0] minutes;
        logic       on_off;
        logic       ack;
        int         tag;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[23];
    int   total;
    int   bad;
    int   e_h;
    int   e_m;

    set_alarm_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .set_alarm_en (set_alarm_en),
        .mode_button  (mode_button),
        .inc_button   (inc_button),
        .o_hours      (o_hours),
        .o_minutes    (o_minutes),
        .ack_flag     (ack_flag),
        .on_off_alarm (on_off_alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pops the oldest expectation and compares it with what the DUT shows after the edge.
    task automatic checkOutput();
        exp_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_empty: actual=queue empty required=one pending entry");
        end else begin
            e = exp_q.pop_front();
            if (o_hours !== e.hours || o_minutes !== e.minutes ||
                on_off_alarm !== e.on_off || ack_flag !== e.ack) begin
                bad++;
                $display("[TB] FAIL step%0d: actual h=%0d m=%0d on=%0b ack=%0b required h=%0d m=%0d on=%0b ack=%0b",
                         e.tag, o_hours, o_minutes, on_off_alarm, ack_flag,
                         e.hours, e.minutes, e.on_off, e.ack);
            end
        end
    endtask

    // Drives one cycle of inputs, queues the expected outputs, then checks after the edge.
    task automatic applyStimulus(input logic r, input logic en, input logic md, input logic ic,
                                 input int h, input int m, input logic on, input logic ak,
                                 input int tag);
        exp_t e;
        rst          = r;
        set_alarm_en = en;
        mode_button  = md;
        inc_button   = ic;
        e.hours   = 5'(h);
        e.minutes = 6'(m);
        e.on_off  = on;
        e.ack     = ak;
        e.tag     = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=time limit reached required=test completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b0; set_alarm_en = 1'b0; mode_button = 1'b0; inc_button = 1'b0;

        //           rst en md ic   h  m  on ack
        vecs[0]  = '{1, 0, 0, 0, 5'd0, 6'd0, 0, 0};
        vecs[1]  = '{0, 1, 0, 1, 5'd1, 6'd0, 0, 0};
        vecs[2]  = '{0, 1, 0, 0, 5'd1, 6'd0, 0, 0};
        vecs[3]  = '{0, 1, 1, 0, 5'd1, 6'd0, 0, 0};
        vecs[4]  = '{0, 1, 0, 0, 5'd1, 6'd0, 0, 0};
        vecs[5]  = '{0, 1, 0, 1, 5'd1, 6'd1, 0, 0};
        vecs[6]  = '{0, 1, 0, 0, 5'd1, 6'd1, 0, 0};
        vecs[7]  = '{0, 1, 1, 0, 5'd1, 6'd1, 0, 0};
        vecs[8]  = '{0, 1, 0, 0, 5'd1, 6'd1, 0, 0};
        vecs[9]  = '{0, 1, 0, 1, 5'd1, 6'd1, 1, 0};
        vecs[10] = '{0, 1, 0, 0, 5'd1, 6'd1, 1, 0};
        vecs[11] = '{0, 1, 1, 0, 5'd1, 6'd1, 1, 1};
        vecs[12] = '{0, 1, 0, 0, 5'd1, 6'd1, 1, 0};
        vecs[13] = '{0, 1, 0, 1, 5'd1, 6'd1, 1, 0};
        vecs[14] = '{0, 0, 0, 0, 5'd1, 6'd1, 1, 0};
        vecs[15] = '{0, 0, 0, 1, 5'd1, 6'd1, 1, 0};
        vecs[16] = '{0, 1, 1, 1, 5'd1, 6'd1, 1, 0};
        vecs[17] = '{0, 1, 0, 0, 5'd1, 6'd1, 1, 0};
        vecs[18] = '{0, 1, 0, 1, 5'd1, 6'd2, 1, 0};
        vecs[19] = '{1, 1, 0, 0, 5'd0, 6'd0, 0, 0};
        vecs[20] = '{0, 1, 0, 1, 5'd1, 6'd0, 0, 0};
        vecs[21] = '{0, 0, 0, 0, 5'd1, 6'd0, 0, 0};
        vecs[22] = '{0, 1, 0, 1, 5'd2, 6'd0, 0, 0};

        // Full sequence, DONE hold, IDLE hold, simultaneous press, mid-sequence reset.
        for (int i = 0; i < 23; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].inc,
                          int'(vecs[i].hours), int'(vecs[i].minutes),
                          vecs[i].on_off, vecs[i].ack, i);
        end

        // Hour wrap: 24 pulsed incs return to zero, then minute wrap over 60 incs.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 100);
        e_h = 0;
        for (int i = 0; i < 24; i++) begin
            e_h = (e_h + 1) % 24;
            applyStimulus(0, 1, 0, 1, e_h, 0, 0, 0, 200 + i);
            applyStimulus(0, 1, 0, 0, e_h, 0, 0, 0, 200 + i);
        end
        applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 300);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 301);
        e_m = 0;
        for (int i = 0; i < 60; i++) begin
            e_m = (e_m + 1) % 60;
            applyStimulus(0, 1, 0, 1, 0, e_m, 0, 0, 400 + i);
            applyStimulus(0, 1, 0, 0, 0, e_m, 0, 0, 400 + i);
        end

        // Abort from MINUTES after 5 incs keeps values and gives no ack.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 500);
        applyStimulus(0, 1, 0, 1, 1, 0, 0, 0, 501);
        applyStimulus(0, 1, 0, 0, 1, 0, 0, 0, 502);
        applyStimulus(0, 1, 0, 1, 2, 0, 0, 0, 503);
        applyStimulus(0, 1, 0, 0, 2, 0, 0, 0, 504);
        applyStimulus(0, 1, 1, 0, 2, 0, 0, 0, 505);
        applyStimulus(0, 1, 0, 0, 2, 0, 0, 0, 506);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(0, 1, 0, 1, 2, i, 0, 0, 510 + i);
            applyStimulus(0, 1, 0, 0, 2, i, 0, 0, 510 + i);
        end
        applyStimulus(0, 0, 0, 0, 2, 5, 0, 0, 520);
        applyStimulus(0, 0, 0, 0, 2, 5, 0, 0, 521);
        // Re-entry goes through HOURS: mode lands in MINUTES, so inc bumps minutes not on/off.
        applyStimulus(0, 1, 1, 0, 2, 5, 0, 0, 522);
        applyStimulus(0, 1, 0, 0, 2, 5, 0, 0, 523);
        applyStimulus(0, 1, 0, 1, 2, 6, 0, 0, 524);
        applyStimulus(0, 1, 0, 0, 2, 6, 0, 0, 525);

        // Held inc for 4 cycles in HOURS.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 600);
        for (int i = 1; i <= 4; i++) begin
`ifdef SET_ALARM_EDGE_DETECT_EN
            applyStimulus(0, 1, 0, 1, 1, 0, 0, 0, 600 + i);
`else
            applyStimulus(0, 1, 0, 1, i, 0, 0, 0, 600 + i);
`endif
        end
        applyStimulus(0, 0, 0, 0,
`ifdef SET_ALARM_EDGE_DETECT_EN
                      1,
`else
                      4,
`endif
                      0, 0, 0, 605);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
